rt_rst_ctrl: RTL and testbench

RT_RST_CTRL -- requirements
Module: rt_rst_ctrl

---
 rtl/rt_rst_pkg.sv | 44 ++++
 rtl/rt_rst_sync.sv | 21 ++
 rtl/rt_rst_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rt_rst_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_rst_pkg.sv
// rtl/rt_rst_pkg.sv - reset sequencer state encoding, cause bit indices and default timing constants
package rt_rst_pkg;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 256;
    localparam int unsigned DEF_STAGE_DELAY_CYCLES = 16;
    localparam int unsigned DEF_HOLD_CYCLES        = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        REL_IC,
        REL_PERIPH,
        REL_CORE,
        RUN,
        ASSERT_CORE,
        ASSERT_PERIPH,
        HOLD
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_LOCK = 2'd0,
        CAUSE_SW   = 2'd1,
        CAUSE_DBG  = 2'd2
    } rst_cause_e;

    function automatic logic [2:0] cause_bit(input rst_cause_e b);
        return 3'b001 << b;
    endfunction

    function automatic logic [2:0] req_cause(input logic sw, input logic ndm);
        logic [2:0] c;
        c = 3'b000;
        if (sw)  c = c | cause_bit(CAUSE_SW);
        if (ndm) c = c | cause_bit(CAUSE_DBG);
        return c;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rt_rst_sync.sv
// rtl/rt_rst_sync.sv - two-flop synchronizer with asynchronous active-low clear
module rt_rst_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/rt_rst_ctrl.sv
// rtl/rt_rst_ctrl.sv - staged ic/periph/core reset sequencer; define RT_RST_CTRL_CAUSE_EN for the reset-cause register
module rt_rst_ctrl
    import rt_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned STAGE_DELAY_CYCLES = DEF_STAGE_DELAY_CYCLES,
    parameter int unsigned HOLD_CYCLES        = DEF_HOLD_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    input  logic       ndm_rst_req_i,
    output logic       rst_ic_no,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic       busy_o,
    output logic [2:0] rst_cause_o
);

    localparam int unsigned CNT_MAX = max3(LOCK_STABLE_CYCLES - 1, STAGE_DELAY_CYCLES - 1,
                                           HOLD_CYCLES - 1);
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    rst_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             lock_s;
    logic             lock_lost;
    logic             req;

    rt_rst_sync u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_locked_i),
        .q_o    (lock_s)
    );

    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    // Outside WAIT_LOCK the lock was high when we left it, so a low sample is a loss.
    assign lock_lost = (state != WAIT_LOCK) && !lock_s;
    assign req       = sw_rst_req_i || ndm_rst_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_ic_no     <= 1'b0;
            rst_periph_no <= 1'b0;
            rst_core_no   <= 1'b0;
            busy_o        <= 1'b1;
        end else if (lock_lost) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_ic_no     <= 1'b0;
            rst_periph_no <= 1'b0;
            rst_core_no   <= 1'b0;
            busy_o        <= 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state     <= REL_IC;
                        cnt       <= '0;
                        rst_ic_no <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REL_IC: begin
                    if (cnt == STAGE_LAST) begin
                        state         <= REL_PERIPH;
                        cnt           <= '0;
                        rst_periph_no <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REL_PERIPH: begin
                    if (cnt == STAGE_LAST) begin
                        state       <= REL_CORE;
                        cnt         <= '0;
                        rst_core_no <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REL_CORE: begin
                    state  <= RUN;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
                RUN: begin
                    if (req) begin
                        state       <= ASSERT_CORE;
                        cnt         <= '0;
                        rst_core_no <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                ASSERT_CORE: begin
                    if (cnt == STAGE_LAST) begin
                        state         <= ASSERT_PERIPH;
                        cnt           <= '0;
                        rst_periph_no <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ASSERT_PERIPH: begin
                    if (cnt == STAGE_LAST) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        rst_ic_no <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state         <= WAIT_LOCK;
                    cnt           <= '0;
                    rst_ic_no     <= 1'b0;
                    rst_periph_no <= 1'b0;
                    rst_core_no   <= 1'b0;
                    busy_o        <= 1'b1;
                end
            endcase
        end
    end

`ifdef RT_RST_CTRL_CAUSE_EN
    logic [2:0] cause_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cause_q <= cause_bit(CAUSE_LOCK);
        end else if (lock_lost) begin
            cause_q <= cause_bit(CAUSE_LOCK);
        end else if (state == RUN && req) begin
            cause_q <= req_cause(sw_rst_req_i, ndm_rst_req_i);
        end
    end

    assign rst_cause_o = cause_q;
`else
    assign rst_cause_o = 3'b000;
`endif

endmodule

// File: tb/tb_rt_rst_ctrl.sv
// tb/tb_rt_rst_ctrl.sv - randomized self-checking bench for rt_rst_ctrl against an elapsed-time model
module tb_rt_rst_ctrl;

    localparam int L          = 4;
    localparam int S          = 2;
    localparam int H          = 3;
    localparam int RUN_AT     = L + 2 * S + 1;
    localparam int ASSERT_LEN = 1 + 2 * S + H;

`ifdef RT_RST_CTRL_CAUSE_EN
    localparam logic [2:0] CAUSE_MASK = 3'b111;
`else
    localparam logic [2:0] CAUSE_MASK = 3'b000;
`endif

    logic       clk_i         = 1'b0;
    logic       rst_ni        = 1'b1;
    logic       pll_locked_i  = 1'b0;
    logic       sw_rst_req_i  = 1'b0;
    logic       ndm_rst_req_i = 1'b0;
    logic       rst_ic_no, rst_periph_no, rst_core_no, busy_o;
    logic [2:0] rst_cause_o;
    logic [6:0] obs;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: cycles of stable lock seen since the last wait entry, or cycles since a request.
    int         m_stable = 0;
    int         m_a      = 0;
    logic       m_assert = 1'b0;
    logic       m_l1     = 1'b0;
    logic       m_l2     = 1'b0;
    logic [2:0] m_cause  = 3'b000;

    always #5 clk_i = ~clk_i;

    rt_rst_ctrl #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_DELAY_CYCLES (S),
        .HOLD_CYCLES        (H)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pll_locked_i  (pll_locked_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .ndm_rst_req_i (ndm_rst_req_i),
        .rst_ic_no     (rst_ic_no),
        .rst_periph_no (rst_periph_no),
        .rst_core_no   (rst_core_no),
        .busy_o        (busy_o),
        .rst_cause_o   (rst_cause_o)
    );

    assign obs = {rst_ic_no, rst_periph_no, rst_core_no, busy_o, rst_cause_o};

    function automatic logic [2:0] en_cause(input logic [2:0] c);
        return c & CAUSE_MASK;
    endfunction

    task automatic model_reset();
        m_stable = 0;
        m_a      = 0;
        m_assert = 1'b0;
        m_l1     = 1'b0;
        m_l2     = 1'b0;
        m_cause  = en_cause(3'b001);
    endtask

    task automatic model_edge();
        logic ls;
        logic waiting;
        ls      = m_l2;
        m_l2    = m_l1;
        m_l1    = pll_locked_i;
        waiting = !m_assert && (m_stable < L);
        if (!ls) begin
            if (!waiting) m_cause = en_cause(3'b001);
            m_assert = 1'b0;
            m_stable = 0;
        end else if (m_assert) begin
            m_a++;
            if (m_a >= ASSERT_LEN) begin
                m_assert = 1'b0;
                m_stable = 0;
            end
        end else if (m_stable >= RUN_AT && (sw_rst_req_i || ndm_rst_req_i)) begin
            m_assert = 1'b1;
            m_a      = 1;
            m_cause  = en_cause({ndm_rst_req_i, sw_rst_req_i, 1'b0});
        end else begin
            m_stable++;
        end
    endtask

    function automatic logic [6:0] exp_vec();
        if (m_assert)
            return {m_a < 1 + 2 * S, m_a < 1 + S, 1'b0, 1'b1, m_cause};
        return {m_stable >= L, m_stable >= L + S, m_stable >= L + 2 * S, m_stable < RUN_AT, m_cause};
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic do_release();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic hold_reset();
        rst_ni = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        pll_locked_i = 1'b1;
        #2;
        hold_reset();
        n_chk++; if (rst_ic_no !== 1'b0) begin n_fail++; $display("FAIL reset_ic: got %b want 0", rst_ic_no); end
        n_chk++; if (rst_periph_no !== 1'b0) begin n_fail++; $display("FAIL reset_periph: got %b want 0", rst_periph_no); end
        n_chk++; if (rst_core_no !== 1'b0) begin n_fail++; $display("FAIL reset_core: got %b want 0", rst_core_no); end
        n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy_o); end
        n_chk++; if (rst_cause_o !== en_cause(3'b001)) begin n_fail++; $display("FAIL reset_cause: got %b want %b", rst_cause_o, en_cause(3'b001)); end
    endtask

    task automatic test_release();
        int ic_k, pe_k, co_k, run_k;
        ic_k = -1; pe_k = -1; co_k = -1; run_k = -1;
        do_release();
        for (int k = 1; k <= 16; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL release_c%0d: got %b want %b", k, obs, exp_vec()); end
            if (rst_ic_no === 1'b1 && ic_k < 0) ic_k = k;
            if (rst_periph_no === 1'b1 && pe_k < 0) pe_k = k;
            if (rst_core_no === 1'b1 && co_k < 0) co_k = k;
            if (busy_o === 1'b0 && run_k < 0) run_k = k;
        end
        n_chk++; if (ic_k != L + 2) begin n_fail++; $display("FAIL release_ic_cycle: got %0d want %0d", ic_k, L + 2); end
        n_chk++; if (pe_k != L + 2 + S) begin n_fail++; $display("FAIL release_periph_cycle: got %0d want %0d", pe_k, L + 2 + S); end
        n_chk++; if (co_k != L + 2 + 2 * S) begin n_fail++; $display("FAIL release_core_cycle: got %0d want %0d", co_k, L + 2 + 2 * S); end
        n_chk++; if (run_k != L + 3 + 2 * S) begin n_fail++; $display("FAIL release_run_cycle: got %0d want %0d", run_k, L + 3 + 2 * S); end
    endtask

    task automatic test_lock_glitch();
        int d, ic_k;
        d    = $urandom_range(3, 6);
        ic_k = -1;
        hold_reset();
        pll_locked_i = 1'b1;
        do_release();
        for (int k = 1; k <= 24; k++) begin
            pll_locked_i = !((k - 1) == 2 || (k - 1) == d);
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_c%0d: got %b want %b", k, obs, exp_vec()); end
            if (rst_ic_no === 1'b1 && ic_k < 0) ic_k = k;
        end
        pll_locked_i = 1'b1;
        n_chk++; if (ic_k != d + 3 + L) begin n_fail++; $display("FAIL glitch_ic_cycle: got %0d want %0d", ic_k, d + 3 + L); end
    endtask

    task automatic test_sw_req();
        int co_f, pe_f, ic_f, ic_r;
        co_f = -1; pe_f = -1; ic_f = -1; ic_r = -1;
        sw_rst_req_i = 1'b1;
        for (int r = 1; r <= 30; r++) begin
            step();
            sw_rst_req_i = 1'b0;
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL sw_c%0d: got %b want %b", r, obs, exp_vec()); end
            if (rst_core_no === 1'b0 && co_f < 0) co_f = r;
            if (rst_periph_no === 1'b0 && pe_f < 0) pe_f = r;
            if (ic_f > 0 && rst_ic_no === 1'b1 && ic_r < 0) ic_r = r;
            if (rst_ic_no === 1'b0 && ic_f < 0) ic_f = r;
        end
        n_chk++; if (co_f != 1) begin n_fail++; $display("FAIL sw_core_fall: got %0d want 1", co_f); end
        n_chk++; if (pe_f != 1 + S) begin n_fail++; $display("FAIL sw_periph_fall: got %0d want %0d", pe_f, 1 + S); end
        n_chk++; if (ic_f != 1 + 2 * S) begin n_fail++; $display("FAIL sw_ic_fall: got %0d want %0d", ic_f, 1 + 2 * S); end
        n_chk++; if (ic_r != ASSERT_LEN + L) begin n_fail++; $display("FAIL sw_ic_rerise: got %0d want %0d", ic_r, ASSERT_LEN + L); end
        n_chk++; if (rst_cause_o !== en_cause(3'b010)) begin n_fail++; $display("FAIL sw_cause: got %b want %b", rst_cause_o, en_cause(3'b010)); end
    endtask

    task automatic test_both_req();
        int falls;
        logic prev;
        falls = 0;
        prev  = rst_core_no;
        sw_rst_req_i  = 1'b1;
        ndm_rst_req_i = 1'b1;
        for (int r = 1; r <= 30; r++) begin
            step();
            sw_rst_req_i  = 1'b0;
            ndm_rst_req_i = 1'b0;
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL both_c%0d: got %b want %b", r, obs, exp_vec()); end
            if (prev === 1'b1 && rst_core_no === 1'b0) falls++;
            prev = rst_core_no;
        end
        n_chk++; if (falls != 1) begin n_fail++; $display("FAIL both_sequences: got %0d want 1", falls); end
        n_chk++; if (rst_cause_o !== en_cause(3'b110)) begin n_fail++; $display("FAIL both_cause: got %b want %b", rst_cause_o, en_cause(3'b110)); end
    endtask

    task automatic test_ndm_level();
        int falls;
        logic prev;
        falls = 0;
        prev  = rst_core_no;
        ndm_rst_req_i = 1'b1;
        for (int r = 1; r <= 40; r++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL ndm_c%0d: got %b want %b", r, obs, exp_vec()); end
            if (prev === 1'b1 && rst_core_no === 1'b0) falls++;
            prev = rst_core_no;
        end
        ndm_rst_req_i = 1'b0;
        n_chk++; if (falls != (40 - 1) / (ASSERT_LEN + RUN_AT) + 1) begin n_fail++; $display("FAIL ndm_sequences: got %0d want %0d", falls, (40 - 1) / (ASSERT_LEN + RUN_AT) + 1); end
        for (int r = 1; r <= 20; r++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL ndm_settle_c%0d: got %b want %b", r, obs, exp_vec()); end
        end
    endtask

    task automatic test_lock_drop();
        int low_k;
        low_k = -1;
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        step();
        step();
        pll_locked_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL drop_assert_c%0d: got %b want %b", n, obs, exp_vec()); end
        end
        n_chk++; if ({rst_ic_no, rst_periph_no, rst_core_no} !== 3'b000) begin n_fail++; $display("FAIL drop_assert_outputs: got %b want 000", {rst_ic_no, rst_periph_no, rst_core_no}); end
        n_chk++; if (rst_cause_o !== en_cause(3'b001)) begin n_fail++; $display("FAIL drop_assert_cause: got %b want %b", rst_cause_o, en_cause(3'b001)); end
        pll_locked_i = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL drop_relock_c%0d: got %b want %b", n, obs, exp_vec()); end
        end
        pll_locked_i = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL drop_run_c%0d: got %b want %b", n, obs, exp_vec()); end
            if ({rst_ic_no, rst_periph_no, rst_core_no} === 3'b000 && low_k < 0) low_k = n;
        end
        n_chk++; if (low_k != 3) begin n_fail++; $display("FAIL drop_run_latency: got %0d want 3", low_k); end
        pll_locked_i = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL drop_final_c%0d: got %b want %b", n, obs, exp_vec()); end
        end
    endtask

    task automatic test_async_reset();
        int ic_k, run_k;
        ic_k = -1; run_k = -1;
        hold_reset();
        do_release();
        for (int k = 1; k <= L + 2 + S; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL arst_pre_c%0d: got %b want %b", k, obs, exp_vec()); end
        end
        #2;
        hold_reset();
        n_chk++; if (obs !== {4'b0001, en_cause(3'b001)}) begin n_fail++; $display("FAIL arst_immediate: got %b want %b", obs, {4'b0001, en_cause(3'b001)}); end
        do_release();
        for (int k = 1; k <= 16; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL arst_post_c%0d: got %b want %b", k, obs, exp_vec()); end
            if (rst_ic_no === 1'b1 && ic_k < 0) ic_k = k;
            if (busy_o === 1'b0 && run_k < 0) run_k = k;
        end
        n_chk++; if (ic_k != L + 2) begin n_fail++; $display("FAIL arst_ic_cycle: got %0d want %0d", ic_k, L + 2); end
        n_chk++; if (run_k != L + 3 + 2 * S) begin n_fail++; $display("FAIL arst_run_cycle: got %0d want %0d", run_k, L + 3 + 2 * S); end
    endtask

    task automatic test_random();
        int low_left;
        low_left = 0;
        for (int k = 1; k <= 800; k++) begin
            if (low_left > 0) begin
                pll_locked_i = 1'b0;
                low_left--;
            end else if (($urandom % 50) == 0) begin
                pll_locked_i = 1'b0;
                low_left = $urandom_range(0, 5);
            end else begin
                pll_locked_i = 1'b1;
            end
            sw_rst_req_i = (($urandom % 25) == 0);
            if (($urandom % 40) == 0) ndm_rst_req_i = !ndm_rst_req_i;
            step();
            n_chk++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_c%0d: got %b want %b", k, obs, exp_vec()); end
        end
        sw_rst_req_i  = 1'b0;
        ndm_rst_req_i = 1'b0;
        pll_locked_i  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_release();
        test_lock_glitch();
        test_sw_req();
        test_both_req();
        test_ndm_level();
        test_lock_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
